pipe_skid: RTL and testbench
============================

PIPE_SKID -- requirements
Module: pipe_skid

Interface
REQ-001 SHALL have parameter NN, default 16, data width in bits.
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream beat present.
REQ-005 SHALL have port in_ready  output  1  stage can accept a beat; driven directly from a flop.
REQ-006 SHALL have port in_data  input  NN  upstream data.
REQ-007 SHALL have port out_valid  output  1  downstream beat present.
REQ-008 SHALL have port out_ready  input  1  downstream accepts.
REQ-009 SHALL have port out_data  output  NN  downstream data, sourced from the main register.
REQ-010 SHALL have port level  output  2  stored beat count, 0..2.

Function
REQ-011 SHALL treat a transfer as in_valid&in_ready (accept) or out_valid&out_ready (drain), sampled at the rising clk edge.
REQ-012 SHALL implement states EMPTY (level 0), HALF (main full, level 1) and FULL (main and skid full, level 2).
REQ-013 SHALL, from EMPTY on accept: main<=in_data, go HALF.
REQ-014 SHALL, from HALF on accept+drain: main<=in_data, stay HALF; on accept only: skid<=in_data, go FULL; on drain only: go EMPTY.
REQ-015 SHALL, from FULL on drain: main<=skid, go HALF; no accept is possible in FULL.
REQ-016 SHALL drive out_valid=1 in HALF and FULL, 0 in EMPTY; in_ready=0 in FULL, 1 otherwise, both registered.
REQ-017 SHALL give 1-cycle latency from accept to out_valid in EMPTY and sustain 1 beat/cycle while out_ready=1.
REQ-018 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-019 SHALL preserve beat order; no beat dropped or duplicated.
REQ-020 SHALL ignore in_data when in_valid=0, and ignore in_valid when in_ready=0.

Reset
REQ-021 SHALL, while reset=1, force state EMPTY, level 0, out_valid 0, in_ready 0, main and skid to 0, out_data 0.
REQ-022 SHALL raise in_ready on the first rising clk edge after reset deasserts.
REQ-023 SHALL discard any stored beats when reset asserts mid-operation; no beat emerges after reset.

Configuration
REQ-024 SHALL, with PIPE_SKID_FLUSH_EN defined, add port flush  input  1  synchronous discard.
REQ-025 SHALL, on flush=1 at a clk edge, go EMPTY, level 0, out_valid 0, in_ready 1, regardless of simultaneous accept/drain; a beat accepted that edge is dropped.
REQ-026 SHALL, without PIPE_SKID_FLUSH_EN, omit the flush port and flush logic entirely.

Structure
REQ-027 SHALL place the state enum (EMPTY/HALF/FULL) and the default width constant in shared package fmdsp_pipe_pkg.
REQ-028 SHALL instantiate sub-module skid_reg (NN-bit enabled register, async reset to 0) for the main and skid registers.

Verification
REQ-029 SHALL cover: reset release, in_valid=1 with data 0x1234 and out_ready=1 -> out_valid at the next edge with out_data 0x1234, level 1.
REQ-030 SHALL cover: out_ready=0, push 0xAAAA then 0xBBBB -> level 2, in_ready=0, out_data holds 0xAAAA; out_ready=1 -> 0xAAAA then 0xBBBB.
REQ-031 SHALL cover: 100 beats 0..99 with in_valid=1 and out_ready=1 -> 100 outputs in order, one per cycle, level stays 1.
REQ-032 SHALL cover: random in_valid/out_ready for 10000 cycles -> scoreboard order-exact, out_data stable while stalled.
REQ-033 SHALL cover: reset asserted in FULL -> out_valid, level, out_data 0 immediately; none of the stored beats appear later.
REQ-034 SHALL cover, with PIPE_SKID_FLUSH_EN: flush in FULL with a simultaneous accept of 0x5555 -> next cycle level 0, out_valid 0, in_ready 1, 0x5555 never emerges.

Source files
------------

// File: rtl/fmdsp_pipe_pkg.sv
// Shared types and constants for the fmdsp pipeline stages.
// Holds the skid-buffer state encoding (which doubles as the stored beat count) and the default width.
package fmdsp_pipe_pkg;

  localparam int DEFAULT_NN = 16;

  // Encoding chosen so the state value equals the number of stored beats.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Enabled data register with asynchronous clear.
// Used for both the main (output) and skid (overflow) slots of pipe_skid.
module skid_reg
  import fmdsp_pipe_pkg::*;
#(
  parameter int NN = DEFAULT_NN
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [NN-1:0] d,
  output logic [NN-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/pipe_skid.sv
// Two-entry skid buffer with a registered in_ready and a registered out_valid.
// Optional synchronous flush port when PIPE_SKID_FLUSH_EN is defined.
module pipe_skid
  import fmdsp_pipe_pkg::*;
#(
  parameter int NN = DEFAULT_NN
) (
  input  logic          clk,
  input  logic          reset,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic          flush,
`endif
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NN-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NN-1:0] out_data,
  output logic [1:0]    level
);

  skid_state_t state, state_nxt;
  logic in_ready_q, out_valid_q;
  logic accept, drain;
  logic main_en, skid_en, main_from_skid;
  logic [NN-1:0] main_d, main_q, skid_q;

  assign accept = in_valid & in_ready_q;
  assign drain  = out_valid_q & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      in_ready_q  <= (state_nxt != FULL);
      out_valid_q <= (state_nxt != EMPTY);
    end
  end

  always_comb begin
    state_nxt      = state;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          main_en   = 1'b1;
          state_nxt = HALF;
        end
      end
      HALF: begin
        if (accept && drain) begin
          main_en = 1'b1;
        end else if (accept) begin
          skid_en   = 1'b1;
          state_nxt = FULL;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so the only possible event is a drain.
        if (drain) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = HALF;
        end
      end
      default: state_nxt = EMPTY;
    endcase
`ifdef PIPE_SKID_FLUSH_EN
    // Flush overrides everything; a beat offered on the same edge is dropped.
    if (flush) begin
      state_nxt      = EMPTY;
      main_en        = 1'b0;
      skid_en        = 1'b0;
      main_from_skid = 1'b0;
    end
`endif
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  skid_reg #(.NN(NN)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  skid_reg #(.NN(NN)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_data),
    .q     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign level     = 2'(state);

endmodule

// File: tb/tb_pipe_skid.sv
// Self-checking bench for pipe_skid: a queue model predicts level/handshake/data each cycle.
// Inputs change on the falling edge; outputs are sampled there too, away from the active edge.
module tb_pipe_skid;

  localparam int NN = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush_drv;
  logic          in_valid;
  logic          in_ready;
  logic [NN-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [NN-1:0] out_data;
  logic [1:0]    level;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;
  logic [NN-1:0] sb[$];

  pipe_skid #(.NN(NN)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef PIPE_SKID_FLUSH_EN
    .flush     (flush_drv),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare DUT outputs against the model state before this cycle's edge.
  task automatic checkOutput();
    int n;
    n = sb.size();
    check("level", 32'(level), 32'(n));
    check("in_ready", 32'(in_ready), 32'(n < 2));
    check("out_valid", 32'(out_valid), 32'(n > 0));
    if (n > 0) check("out_data", 32'(out_data), 32'(sb[0]));
  endtask

  // Check, drive one cycle of inputs, update the model, and advance to the next falling edge.
  task automatic applyStimulus(input logic iv, input logic [NN-1:0] d, input logic ordy);
    int n;
    n = sb.size();
    checkOutput();
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    if (flush_drv) begin
      sb.delete();
    end else begin
      if (ordy && n > 0) begin
        void'(sb.pop_front());
        pops++;
      end
      if (iv && n < 2) begin
        sb.push_back(d);
        pushes++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    flush_drv = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Values held during reset.
    @(negedge clk);
    @(negedge clk);
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);

    reset = 1'b0;
    #1 check("rel_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rel_in_ready_high", 32'(in_ready), 32'd1);

    $display("[TB] single beat 0x1234");
    applyStimulus(1'b1, 16'h1234, 1'b1);
    check("single_level", 32'(level), 32'd1);
    check("single_data", 32'(out_data), 32'h1234);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] fill to FULL under backpressure");
    applyStimulus(1'b1, 16'hAAAA, 1'b0);
    applyStimulus(1'b1, 16'hBBBB, 1'b0);
    check("full_level", 32'(level), 32'd2);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_data", 32'(out_data), 32'hAAAA);
    applyStimulus(1'b1, 16'hCCCC, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    check("drain_second", 32'(out_data), 32'hBBBB);
    applyStimulus(1'b0, 16'h0000, 1'b1);
    applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] streaming 100 beats");
    pushes = 0;
    pops   = 0;
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, NN'(i), 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    check("stream_pushes", 32'(pushes), 32'd100);
    check("stream_pops", 32'(pops), 32'd100);

    $display("[TB] random traffic");
    for (int i = 0; i < 10000; i++)
      applyStimulus(1'($urandom_range(0, 1)), NN'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

    $display("[TB] reset while FULL");
    applyStimulus(1'b1, 16'h1111, 1'b0);
    applyStimulus(1'b1, 16'h2222, 1'b0);
    checkOutput();
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b1);

`ifdef PIPE_SKID_FLUSH_EN
    $display("[TB] flush while FULL with offered beat");
    applyStimulus(1'b1, 16'h3333, 1'b0);
    applyStimulus(1'b1, 16'h4444, 1'b0);
    flush_drv = 1'b1;
    applyStimulus(1'b1, 16'h5555, 1'b1);
    flush_drv = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
    $display("[TB] flush while HALF drops the accepted beat");
    applyStimulus(1'b1, 16'h6666, 1'b0);
    flush_drv = 1'b1;
    applyStimulus(1'b1, 16'h5555, 1'b0);
    flush_drv = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0000, 1'b1);
`endif

    checkOutput();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
